// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: DEPTH-entry circular skid buffer on a valid/ready stream.
// Ports: clk, rst (sync, active-high); s_in_tdata/tvalid/tready upstream;
//   m_out_tdata/tvalid/tready downstream; occupancy, afull status.
// Option: define STREAM_SKID_FIFO_TLAST_EN to add s_in_tlast, m_out_tlast
//   and packet_cnt (stored beats carrying tlast=1).
module stream_skid_fifo #(
  parameter int DWIDTH       = 32,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DWIDTH-1:0]        s_in_tdata,
  input  logic                     s_in_tvalid,
  output logic                     s_in_tready,
`ifdef STREAM_SKID_FIFO_TLAST_EN
  input  logic                     s_in_tlast,
  output logic                     m_out_tlast,
  output logic [$clog2(DEPTH):0]   packet_cnt,
`endif
  output logic [DWIDTH-1:0]        m_out_tdata,
  output logic                     m_out_tvalid,
  input  logic                     m_out_tready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     afull
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef STREAM_SKID_FIFO_TLAST_EN
  localparam int MW = DWIDTH + 1;
`else
  localparam int MW = DWIDTH;
`endif

  logic [MW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_s_rdy;
  logic          r_m_vld;
  logic          r_afull;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_next;
  logic [MW-1:0] w_wr_word;
  logic [MW-1:0] w_rd_word;

  assign w_push = s_in_tvalid & r_s_rdy;
  assign w_pop  = r_m_vld & m_out_tready;

  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

`ifdef STREAM_SKID_FIFO_TLAST_EN
  assign w_wr_word = {s_in_tlast, s_in_tdata};
`else
  assign w_wr_word = s_in_tdata;
`endif

  assign w_rd_word    = r_mem[r_rd_ptr];
  assign m_out_tdata  = w_rd_word[DWIDTH-1:0];
  assign m_out_tvalid = r_m_vld;
  assign s_in_tready  = r_s_rdy;
  assign afull        = r_afull;
  assign occupancy    = r_count;

  // Storage needs no reset; contents are ignored until written.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= w_wr_word;
  end

  // Flags come from count_next so both handshake paths are cut
  // while still allowing a beat every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_s_rdy  <= 1'b0;
      r_m_vld  <= 1'b0;
      r_afull  <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      r_s_rdy <= (w_count_next != CW'(DEPTH));
      r_m_vld <= (w_count_next != '0);
      r_afull <= (w_count_next >= CW'(AFULL_THRESH));
    end
  end

`ifdef STREAM_SKID_FIFO_TLAST_EN
  logic [CW-1:0] r_pkt;
  logic          w_pk_inc;
  logic          w_pk_dec;

  assign m_out_tlast = w_rd_word[DWIDTH];
  assign w_pk_inc    = w_push & s_in_tlast;
  assign w_pk_dec    = w_pop & m_out_tlast;
  assign packet_cnt  = r_pkt;

  always_ff @(posedge clk) begin
    if (rst)
      r_pkt <= '0;
    else
      r_pkt <= r_pkt + CW'(w_pk_inc) - CW'(w_pk_dec);
  end
`endif

`ifndef SYNTHESIS
  logic              r_chk_stall;
  logic [DWIDTH-1:0] r_chk_data;

  always @(posedge clk) begin
    if (!rst) begin
      assert (r_count <= CW'(DEPTH))
        else $error("count overflow %0d", r_count);
      assert (!(w_pop && r_count == '0))
        else $error("count underflow");
    end
    if (r_chk_stall)
      assert (m_out_tdata == r_chk_data)
        else $error("m_out_tdata changed while stalled");
    r_chk_stall <= r_m_vld & ~m_out_tready & ~rst;
    r_chk_data  <= m_out_tdata;
  end
`endif

endmodule

// File: tb/tb_stream_skid_fifo.sv
// tb_stream_skid_fifo: directed and random scoreboard bench for
// stream_skid_fifo (DEPTH=4), optional tlast section.
module tb_stream_skid_fifo;

  localparam int DW = 32;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_in_tdata;
  logic          s_in_tvalid;
  logic          s_in_tready;
  logic [DW-1:0] m_out_tdata;
  logic          m_out_tvalid;
  logic          m_out_tready;
  logic [2:0]    occupancy;
  logic          afull;
`ifdef STREAM_SKID_FIFO_TLAST_EN
  logic          s_in_tlast;
  logic          m_out_tlast;
  logic [2:0]    packet_cnt;
`endif

  stream_skid_fifo #(.DWIDTH(DW), .DEPTH(DP), .AFULL_THRESH(DP-1)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_in_tdata   (s_in_tdata),
    .s_in_tvalid  (s_in_tvalid),
    .s_in_tready  (s_in_tready),
`ifdef STREAM_SKID_FIFO_TLAST_EN
    .s_in_tlast   (s_in_tlast),
    .m_out_tlast  (m_out_tlast),
    .packet_cnt   (packet_cnt),
`endif
    .m_out_tdata  (m_out_tdata),
    .m_out_tvalid (m_out_tvalid),
    .m_out_tready (m_out_tready),
    .occupancy    (occupancy),
    .afull        (afull)
  );

  always #5 clk = ~clk;

  int            n_chk  = 0;
  int            n_fail = 0;
  int            n_pops = 0;
  bit            post_rst = 1'b0;
  bit            last_push;
  bit            last_pop;
  logic [DW-1:0] q[$];
`ifdef STREAM_SKID_FIFO_TLAST_EN
  bit            ql[$];
`endif

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample between edges, compare against the scoreboard, then
  // apply the handshake that the coming edge will perform.
  task automatic step();
    int sz;
    @(negedge clk);
    sz = q.size();
    chk("occupancy", 64'(occupancy), 64'(sz));
    chk("m_out_tvalid", 64'(m_out_tvalid), 64'(sz != 0));
    chk("s_in_tready", 64'(s_in_tready), 64'((sz != DP) && !post_rst));
    chk("afull", 64'(afull), 64'(sz >= DP - 1));
    if (m_out_tvalid && sz != 0)
      chk("m_out_tdata", 64'(m_out_tdata), 64'(q[0]));
`ifdef STREAM_SKID_FIFO_TLAST_EN
    begin
      int np = 0;
      foreach (ql[i]) np += int'(ql[i]);
      chk("packet_cnt", 64'(packet_cnt), 64'(np));
      if (m_out_tvalid && sz != 0)
        chk("m_out_tlast", 64'(m_out_tlast), 64'(ql[0]));
    end
`endif
    last_push = s_in_tvalid && s_in_tready;
    last_pop  = m_out_tvalid && m_out_tready;
    if (last_pop && sz != 0) begin
      void'(q.pop_front());
`ifdef STREAM_SKID_FIFO_TLAST_EN
      void'(ql.pop_front());
`endif
      n_pops++;
    end
    if (last_push) begin
      q.push_back(s_in_tdata);
`ifdef STREAM_SKID_FIFO_TLAST_EN
      ql.push_back(s_in_tlast);
`endif
    end
    post_rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    s_in_tvalid  = 1'b0;
    m_out_tready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
`ifdef STREAM_SKID_FIFO_TLAST_EN
    ql.delete();
`endif
    post_rst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed;
    int iters;
    rst          = 1'b1;
    s_in_tdata   = '0;
    s_in_tvalid  = 1'b0;
    m_out_tready = 1'b0;
`ifdef STREAM_SKID_FIFO_TLAST_EN
    s_in_tlast   = 1'b0;
`endif
    @(posedge clk);
    #1;
    do_reset();
    step();

    // Fill to full with the consumer stalled.
    for (int i = 0; i < 4; i++) begin
      s_in_tvalid = 1'b1;
      s_in_tdata  = 32'hA0 + 32'(i);
      step();
    end
    s_in_tvalid = 1'b0;
    step();
    chk("full_occ", 64'(occupancy), 64'd4);
    chk("full_head", 64'(m_out_tdata), 64'hA0);

    // Drain in order.
    n_pops = 0;
    m_out_tready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("drain_pops", 64'(n_pops), 64'd4);

    // Continuous stream, ready and valid both high.
    n_pops = 0;
    for (int i = 0; i < 32; i++) begin
      s_in_tvalid = 1'b1;
      s_in_tdata  = 32'(i);
      step();
      if (i > 0)
        chk("stream_pop", 64'(last_pop), 64'd1);
    end
    s_in_tvalid = 1'b0;
    step();
    chk("stream_pops", 64'(n_pops), 64'd32);
    step();

    // Random valid/ready, 1000 beats.
    pushed = 0;
    iters  = 0;
    while (pushed < 1000 && iters < 8000) begin
      s_in_tvalid  = 1'($urandom_range(0, 1));
      m_out_tready = 1'($urandom_range(0, 1));
      s_in_tdata   = 32'h1000 + 32'(pushed);
      step();
      if (last_push) pushed++;
      iters++;
    end
    chk("rand_pushed", 64'(pushed), 64'd1000);
    s_in_tvalid  = 1'b0;
    m_out_tready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("rand_drained", 64'(occupancy), 64'd0);

    // Reset mid-stream drops stored beats.
    m_out_tready = 1'b0;
    s_in_tvalid  = 1'b1;
    s_in_tdata = 32'h11; step();
    s_in_tdata = 32'h22; step();
    s_in_tdata = 32'h33; step();
    chk("pre_rst_occ", 64'(occupancy), 64'd3);
    do_reset();
    step();
    s_in_tvalid = 1'b1;
    s_in_tdata  = 32'h44;
    step();
    s_in_tvalid  = 1'b0;
    m_out_tready = 1'b1;
    chk("post_rst_head", 64'(m_out_tdata), 64'h44);
    step();
    step();

`ifdef STREAM_SKID_FIFO_TLAST_EN
    m_out_tready = 1'b0;
    s_in_tvalid  = 1'b1;
    s_in_tdata = 32'h1; s_in_tlast = 1'b0; step();
    s_in_tdata = 32'h2; s_in_tlast = 1'b1; step();
    s_in_tdata = 32'h3; s_in_tlast = 1'b1; step();
    s_in_tvalid = 1'b0;
    s_in_tlast  = 1'b0;
    step();
    chk("pkt_full", 64'(packet_cnt), 64'd2);
    m_out_tready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("pkt_empty", 64'(packet_cnt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_skid_fifo.md
Name: stream_skid_fifo

Overview:
- Parametrised successor to the two-entry stream register slice: a DEPTH-entry circular skid buffer on a valid/ready stream.
- Full throughput (one beat per cycle). Fully cuts both timing paths:
  - no combinational path from s_in_* to m_out_*;
  - no combinational path from m_out_tready to s_in_tready.
- Adds occupancy and almost-full status for upstream flow control.
- Sits between data-route stages and PE-array feeders wherever a long route needs pipelining plus elasticity.

Parameters:
DWIDTH, 32, payload width in bits (>=1)
DEPTH, 4, number of storage entries; power of two, >=2
AFULL_THRESH, DEPTH-1, occupancy at or above which afull asserts (1..DEPTH)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
s_in_tdata  input  DWIDTH  upstream payload
s_in_tvalid  input  1  upstream valid
s_in_tready  output  1  upstream ready; registered
m_out_tdata  output  DWIDTH  downstream payload; entry at read pointer
m_out_tvalid  output  1  downstream valid; registered
m_out_tready  input  1  downstream ready
occupancy  output  $clog2(DEPTH)+1  entries currently stored
afull  output  1  occupancy >= AFULL_THRESH; registered

Behaviour:
- Handshake events:
  - push = s_in_tvalid & s_in_tready
  - pop = m_out_tvalid & m_out_tready
  - Both evaluated in the same cycle and applied at the same edge.
- Storage: array mem[0..DEPTH-1] plus three registers:
  - wr_ptr, rd_ptr, each $clog2(DEPTH) bits; wrap naturally from DEPTH-1 to 0.
  - count, $clog2(DEPTH)+1 bits.
- Next-state rules:
  - push: mem[wr_ptr] <= s_in_tdata; wr_ptr+1.
  - pop: rd_ptr+1.
  - count_next = count + push - pop.
  - occupancy = count.
- Registered outputs, computed from count_next:
  - s_in_tready <= (count_next != DEPTH)
  - m_out_tvalid <= (count_next != 0)
  - afull <= (count_next >= AFULL_THRESH)
- m_out_tdata = mem[rd_ptr]. It must not change while m_out_tvalid=1 and m_out_tready=0.
- Latency: a beat pushed into an empty buffer at edge N is presented with m_out_tvalid=1 in the cycle after edge N (1-cycle latency).
- Throughput: with m_out_tready held high and s_in_tvalid held high, one beat per cycle indefinitely; count stays at 1.
- Reset (rst=1 at an edge):
  - wr_ptr=0, rd_ptr=0, count=0, occupancy=0.
  - m_out_tvalid=0, s_in_tready=0, afull=0.
  - mem contents don't-care; m_out_tdata don't-care while m_out_tvalid=0.
  - One cycle after rst deasserts: s_in_tready=1.
- Boundaries:
  - Full (count=DEPTH): s_in_tready=0, so no push. A pop makes s_in_tready=1 at the next edge.
  - Empty (count=0): m_out_tvalid=0, so no pop. A push makes m_out_tvalid=1 at the next edge.
  - Simultaneous push and pop at any 0<count<DEPTH: count unchanged; both pointers advance.
  - Pointer wrap: order preserved across the DEPTH-1 to 0 wrap.
  - rst mid-stream: all stored beats dropped; outputs take reset values at that edge.
  - s_in_tvalid while s_in_tready=0: beat not taken. Upstream must hold it (AXI-stream rule; not checked).
- Assertions (simulation only):
  - count never exceeds DEPTH and never underflows.
  - m_out_tdata stable while m_out_tvalid & ~m_out_tready.

Optional Feature:
- Macro: STREAM_SKID_FIFO_TLAST_EN.
- Defined:
  - Adds ports s_in_tlast (input, 1) and m_out_tlast (output, 1).
  - tlast is stored alongside tdata in each entry and emitted with its beat.
  - Adds a packet_cnt output ($clog2(DEPTH)+1 bits): number of stored beats with tlast=1. It increments on a push with tlast=1 and decrements on a pop with tlast=1; both in one cycle leaves it unchanged. Reset value 0.
- Undefined: no tlast ports, no packet_cnt port, no extra storage bit.

Test Plan:
- DEPTH=4. Reset, then push 0xA0..0xA3 with m_out_tready=0 -> occupancy goes 1,2,3,4. afull=1 once occupancy>=3. s_in_tready=0 after 4th push. m_out_tdata=0xA0 held stable.
- From full, raise m_out_tready for 6 cycles -> outputs 0xA0,0xA1,0xA2,0xA3 in order. m_out_tvalid=0 after last pop. s_in_tready=1 one cycle after first pop.
- Continuous stream 0x00..0x1F, both valid and ready held high -> 32 beats out in order, 1-cycle latency, no bubbles, occupancy constant at 1, ptr wrap exercised 8 times.
- Random tvalid/tready (50%/50%), 1000 beats, scoreboard -> exact in-order match, no loss or duplication, count never >4.
- Push 3 beats (0x11,0x22,0x33), assert rst one cycle with m_out_tready=0 -> next cycle occupancy=0, m_out_tvalid=0, s_in_tready=0. s_in_tready=1 one cycle after rst deasserts. Next push 0x44 emerges first.
- TLAST_EN build: push 0x1(last=0), 0x2(last=1), 0x3(last=1) with tready=0 -> packet_cnt=2. Pop all -> m_out_tlast sequence 0,1,1; packet_cnt returns to 0.
